moore_seq_detect: RTL and testbench

Parametrised Moore-type serial sequence detector: the next generation of the team's fixed-pattern "1001" detector. It samples a one-bit serial stream under an enable and compares the last `PAT_W` bits against a pattern that is runtime-loadable. It supports overlapping and non-overlapping detection and keeps a saturating count of matches. It sits on serial control/test streams as a reusable pattern spotter.

---
 rtl/moore_seq_detect.sv | 98 +++++++++
 tb/tb_moore_seq_detect.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detect.sv
// moore_seq_detect: serial pattern spotter with a runtime-loadable pattern.
// The last PAT_W enabled samples are kept in a shift history (newest bit in
// the LSB) and compared against the active pattern (MSB = oldest bit).
// The match flag y is a registered Moore output, and matches are counted in a
// saturating counter.
//
// Handshake: en is a valid-only strobe. x is consumed on every rising edge
// where en=1, and the block is always ready, so there is no backpressure.
// pat_ld takes priority over en, and x/en are discarded in a load cycle.
module moore_seq_detect #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  hist, hist_d;
  logic [FILL_W-1:0] fill, fill_d;
  logic [PAT_W-1:0]  pat_reg, pat_d;
  logic              y_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              sat_d;

  // Candidate values if the current x were sampled this cycle.
  logic [PAT_W-1:0]  samp_hist;
  logic [FILL_W-1:0] samp_fill;
  logic              hit;

  // Next-state logic: pattern load > sample > idle. Defaults hold state and
  // drop the match flag.
  always_comb begin
    hist_d    = hist;
    fill_d    = fill;
    pat_d     = pat_reg;
    y_d       = 1'b0;
    cnt_d     = match_cnt;
    samp_hist = {hist[PAT_W-2:0], x};
    samp_fill = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    // A full window is required, so a cleared history never matches an
    // all-zero pattern.
    hit       = (samp_fill == FILL_FULL) && (samp_hist == pat_reg);

    if (pat_ld) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = samp_hist;
      fill_d = samp_fill;
      if (hit) begin
        y_d = 1'b1;
        if (match_cnt != CNT_MAX) begin
          cnt_d = match_cnt + 1'b1;
        end
        // Non-overlapping mode: the next match needs PAT_W fresh samples.
        if (!OVERLAP) begin
          fill_d = '0;
        end
      end
    end

    sat_d = (cnt_d == CNT_MAX);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist      <= '0;
      fill      <= '0;
      pat_reg   <= PATTERN;
      y         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      hist      <= hist_d;
      fill      <= fill_d;
      pat_reg   <= pat_d;
      y         <= y_d;
      match_cnt <= cnt_d;
      cnt_sat   <= sat_d;
    end
  end

endmodule

// File: tb/tb_moore_seq_detect.sv
// tb_moore_seq_detect: directed checks of moore_seq_detect in three builds.
// dut_a: default build (1001, overlapping, 8-bit counter).
// dut_b: non-overlapping build.
// dut_c: PAT_W=2 with pattern 11 and a 2-bit counter, for saturation.
module tb_moore_seq_detect;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic x;
  logic en;
  logic pat_ld;
  logic [3:0] pat_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       y_a, sat_a;
  logic [7:0] cnt_a;
  logic       y_b, sat_b;
  logic [7:0] cnt_b;
  logic       y_c, sat_c;
  logic [1:0] cnt_c;

  moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .x(x), .en(en), .pat_ld(pat_ld), .pat_in(pat_in),
    .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .x(x), .en(en), .pat_ld(1'b0), .pat_in(4'b1001),
    .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  moore_seq_detect #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .x(x), .en(en), .pat_ld(1'b0), .pat_in(2'b11),
    .y(y_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];   // {y, cnt[7:0], sat}

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs at the falling edge, then sample outputs 1 time
  // unit after the following rising edge.
  task automatic step(input logic r, input logic e, input logic xi,
                      input logic ld, input logic [3:0] p);
    @(negedge clk);
    reset  = r;
    en     = e;
    x      = xi;
    pat_ld = ld;
    pat_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic ey, input logic [7:0] ec, input logic es);
    check({nm, "_y"},   {31'd0, y_a},   {31'd0, ey});
    check({nm, "_cnt"}, {24'd0, cnt_a}, {24'd0, ec});
    check({nm, "_sat"}, {31'd0, sat_a}, {31'd0, es});
  endtask

  task automatic chk_b(input string nm, input logic ey, input logic [7:0] ec);
    check({nm, "_y"},   {31'd0, y_b},   {31'd0, ey});
    check({nm, "_cnt"}, {24'd0, cnt_b}, {24'd0, ec});
  endtask

  task automatic chk_c(input string nm, input logic ey, input logic [1:0] ec, input logic es);
    check({nm, "_y"},   {31'd0, y_c},   {31'd0, ey});
    check({nm, "_cnt"}, {30'd0, cnt_c}, {30'd0, ec});
    check({nm, "_sat"}, {31'd0, sat_c}, {31'd0, es});
  endtask

  // ---------------- vector table (dut_a) ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic       x;
    logic       ld;
    logic [3:0] pat;
    logic       y;
    logic [7:0] cnt;
    logic       sat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic xi, input logic ld,
                     input logic [3:0] p, input logic ey, input logic [7:0] ec,
                     input logic es);
    vec_t v;
    v.rst = r; v.en = e; v.x = xi; v.ld = ld; v.pat = p;
    v.y = ey; v.cnt = ec; v.sat = es;
    tbl.push_back(v);
  endtask

  // Watchdog: the stimulus is finite, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] e;
    reset = 1'b0; en = 1'b0; x = 1'b0; pat_ld = 1'b0; pat_in = 4'b0000;

    //   rst en  x  ld  pat      y  cnt sat
    // reset dominates en/x
    add(0, 1, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0, 0);
    // default overlap stream 1,0,0,1,0,0,1
    add(1, 1, 1, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 1, 1, 0);
    add(1, 1, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 1, 0, 4'b0000, 1, 2, 0);
    // feed 1,0,0 so the next 1 would complete the old pattern
    add(1, 1, 1, 0, 4'b0000, 0, 2, 0);
    add(1, 1, 0, 0, 4'b0000, 0, 2, 0);
    add(1, 1, 0, 0, 4'b0000, 0, 2, 0);
    // load 1101 with x=1/en=1 in the same cycle: no old-pattern match
    add(1, 1, 1, 1, 4'b1101, 0, 2, 0);
    add(1, 1, 1, 0, 4'b0000, 0, 2, 0);
    add(1, 1, 1, 0, 4'b0000, 0, 2, 0);
    add(1, 1, 0, 0, 4'b0000, 0, 2, 0);
    add(1, 1, 1, 0, 4'b0000, 1, 3, 0);
    add(1, 0, 1, 0, 4'b0000, 0, 3, 0);
    add(1, 1, 1, 0, 4'b0000, 0, 3, 0);

    foreach (tbl[i]) begin
      exp_q.push_back({tbl[i].y, tbl[i].cnt, tbl[i].sat});
      step(tbl[i].rst, tbl[i].en, tbl[i].x, tbl[i].ld, tbl[i].pat);
      e = exp_q.pop_front();
      chk_a($sformatf("vec%0d", i), e[9], e[8:1], e[0]);
    end

    // ---- enable gaps: 1,0,0,1 with 3 idle cycles between bits ----
    step(1, 0, 0, 1, 4'b1001);
    chk_a("gap_ld", 0, 3, 0);
    begin
      logic [3:0] bits;
      bits = 4'b1001;
      for (int b = 3; b >= 0; b--) begin
        step(1, 1, bits[b], 0, 4'b0000);
        chk_a($sformatf("gap_bit%0d", 3 - b), (b == 0), (b == 0) ? 8'd4 : 8'd3, 0);
        if (b != 0) begin
          for (int g = 0; g < 3; g++) begin
            step(1, 0, 1'($urandom_range(0, 1)), 0, 4'b0000);
            check($sformatf("gap_idle%0d_%0d_y", 3 - b, g), {31'd0, y_a}, 32'd0);
          end
        end
      end
      step(1, 0, 1, 0, 4'b0000);
      chk_a("gap_after", 0, 4, 0);
    end

    // ---- reset on the edge that would complete 1001 ----
    step(1, 1, 1, 0, 4'b0000);
    step(1, 1, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 4'b0000);
    chk_a("rmid_pre", 0, 4, 0);
    step(0, 1, 1, 0, 4'b0000);
    chk_a("rmid_rst", 0, 0, 0);
    step(1, 1, 0, 0, 4'b0000);
    chk_a("rmid_0", 0, 0, 0);
    step(1, 1, 1, 0, 4'b0000);
    chk_a("rmid_1", 0, 0, 0);

    // ---- all-zero pattern: needs a full window of samples ----
    step(1, 1, 0, 1, 4'b0000);
    chk_a("zero_ld", 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0, 4'b0000);
      chk_a($sformatf("zero_%0d", k), (k >= 3), (k >= 3) ? 8'(k - 2) : 8'd0, 0);
    end

    // ---- non-overlap build: 1,0,0,1,0,0,1 gives one match ----
    step(0, 0, 0, 0, 4'b0000);
    chk_b("nov_rst", 0, 0);
    begin
      logic [6:0] s;
      s = 7'b1001001;
      for (int k = 0; k < 7; k++) begin
        step(1, 1, s[6 - k], 0, 4'b0000);
        chk_b($sformatf("nov_%0d", k), (k == 3), (k >= 3) ? 8'd1 : 8'd0);
      end
    end

    // ---- saturation build: six 1s, counter stops at 3 ----
    step(0, 0, 0, 0, 4'b0000);
    chk_c("sat_rst", 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 1, 0, 4'b0000);
      chk_c($sformatf("sat_%0d", k), (k >= 1), (k >= 3) ? 2'd3 : 2'(k), (k >= 3));
    end
    step(1, 0, 1, 0, 4'b0000);
    chk_c("sat_idle", 0, 3, 1);
    step(0, 1, 1, 0, 4'b0000);
    chk_c("sat_reset", 0, 0, 0);

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
